// File: rtl/axi_rd_arbiter_2to1_pkg.sv
// Shared constants for the 2:1 AXI3 read arbiter: FSM encodings, AXI burst/size codes
// and the default AXI width defines.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package axi_rd_arbiter_2to1_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    // A beat is inconsistent when RLAST disagrees with whether it is the ARLEN-th beat.
    function automatic logic len_mismatch(input logic rlast, input logic [3:0] beat_cnt,
                                          input logic [3:0] arlen);
        return rlast ? (beat_cnt != arlen) : (beat_cnt == arlen);
    endfunction

endpackage

// File: rtl/axi_rd_arb_sel.sv
// Combinational winner select for the read arbiter.
// ARB_ROUND_ROBIN_EN: alternate on contention; otherwise s1 has fixed priority.
module axi_rd_arb_sel (
    input  logic [1:0] ar_valid,
    input  logic       last_grant,
    output logic       winner,
    output logic       any_valid
);

    assign any_valid = |ar_valid;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = ar_valid[1];
        if (&ar_valid) winner = ~last_grant;
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign winner            = ar_valid[1];
`endif

endmodule

// File: rtl/axi_rd_arbiter_2to1.sv
// 2:1 AXI3 read-port arbiter, one outstanding burst; R beats steered by the held grant.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed s1 priority.
module axi_rd_arbiter_2to1
    import axi_rd_arbiter_2to1_pkg::*;
#(
    parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
    parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
    parameter int ID_WIDTH   = `AXI_ID_WIDTH
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ID_WIDTH-1:0]   s0_ARID,
    input  logic [ADDR_WIDTH-1:0] s0_ARADDR,
    input  logic [3:0]            s0_ARLEN,
    input  logic [2:0]            s0_ARSIZE,
    input  logic [1:0]            s0_ARBURST,
    input  logic                  s0_ARVALID,
    output logic                  s0_ARREADY,
    output logic [ID_WIDTH-1:0]   s0_RID,
    output logic [DATA_WIDTH-1:0] s0_RDATA,
    output logic [1:0]            s0_RRESP,
    output logic                  s0_RLAST,
    output logic                  s0_RVALID,
    input  logic                  s0_RREADY,
    input  logic [ID_WIDTH-1:0]   s1_ARID,
    input  logic [ADDR_WIDTH-1:0] s1_ARADDR,
    input  logic [3:0]            s1_ARLEN,
    input  logic [2:0]            s1_ARSIZE,
    input  logic [1:0]            s1_ARBURST,
    input  logic                  s1_ARVALID,
    output logic                  s1_ARREADY,
    output logic [ID_WIDTH-1:0]   s1_RID,
    output logic [DATA_WIDTH-1:0] s1_RDATA,
    output logic [1:0]            s1_RRESP,
    output logic                  s1_RLAST,
    output logic                  s1_RVALID,
    input  logic                  s1_RREADY,
    output logic [ID_WIDTH-1:0]   m_ARID,
    output logic [ADDR_WIDTH-1:0] m_ARADDR,
    output logic [3:0]            m_ARLEN,
    output logic [2:0]            m_ARSIZE,
    output logic [1:0]            m_ARBURST,
    output logic                  m_ARVALID,
    input  logic                  m_ARREADY,
    input  logic [ID_WIDTH-1:0]   m_RID,
    input  logic [DATA_WIDTH-1:0] m_RDATA,
    input  logic [1:0]            m_RRESP,
    input  logic                  m_RLAST,
    input  logic                  m_RVALID,
    output logic                  m_RREADY,
    output logic                  len_err
);

    arb_state_e state_q, state_d;
    logic       grant_q, last_grant_q;
    logic [3:0] beat_cnt_q;
    logic       winner, any_valid;
    logic       ar_hs, r_hs, r_sel_ready;

    axi_rd_arb_sel u_sel (
        .ar_valid  ({s1_ARVALID, s0_ARVALID}),
        .last_grant(last_grant_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // R payload is broadcast; only RVALID/RREADY are steered.
    assign s0_RID   = m_RID;
    assign s0_RDATA = m_RDATA;
    assign s0_RRESP = m_RRESP;
    assign s0_RLAST = m_RLAST;
    assign s1_RID   = m_RID;
    assign s1_RDATA = m_RDATA;
    assign s1_RRESP = m_RRESP;
    assign s1_RLAST = m_RLAST;

    always_comb begin
        state_d     = state_q;
        ar_hs       = 1'b0;
        r_hs        = 1'b0;
        s0_ARREADY  = 1'b0;
        s1_ARREADY  = 1'b0;
        s0_RVALID   = 1'b0;
        s1_RVALID   = 1'b0;
        m_RREADY    = 1'b0;
        r_sel_ready = grant_q ? s1_RREADY : s0_RREADY;
        case (state_q)
            ARB_IDLE: begin
                s0_ARREADY = any_valid & ~winner;
                s1_ARREADY = any_valid & winner;
                ar_hs      = any_valid;
                if (ar_hs) state_d = ARB_ADDR;
            end
            ARB_ADDR: begin
                if (m_ARREADY) state_d = ARB_DATA;
            end
            ARB_DATA: begin
                m_RREADY  = r_sel_ready;
                s0_RVALID = m_RVALID & ~grant_q;
                s1_RVALID = m_RVALID & grant_q;
                r_hs      = m_RVALID & r_sel_ready;
                if (r_hs && m_RLAST) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= ARB_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= 4'd0;
            m_ARID       <= '0;
            m_ARADDR     <= '0;
            m_ARLEN      <= '0;
            m_ARSIZE     <= '0;
            m_ARBURST    <= '0;
            m_ARVALID    <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            state_q <= state_d;
            len_err <= r_hs && len_mismatch(m_RLAST, beat_cnt_q, m_ARLEN);
            if (ar_hs) begin
                grant_q      <= winner;
                last_grant_q <= winner;
                beat_cnt_q   <= 4'd0;
                m_ARID       <= winner ? s1_ARID    : s0_ARID;
                m_ARADDR     <= winner ? s1_ARADDR  : s0_ARADDR;
                m_ARLEN      <= winner ? s1_ARLEN   : s0_ARLEN;
                m_ARSIZE     <= winner ? s1_ARSIZE  : s0_ARSIZE;
                m_ARBURST    <= winner ? s1_ARBURST : s0_ARBURST;
                m_ARVALID    <= 1'b1;
            end else if (state_q == ARB_ADDR && m_ARREADY) begin
                m_ARVALID <= 1'b0;
            end
            if (r_hs) beat_cnt_q <= beat_cnt_q + 4'd1;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter_2to1.sv
// Directed self-checking bench for axi_rd_arbiter_2to1 (default fixed-priority build).
module tb_axi_rd_arbiter_2to1;
    import axi_rd_arbiter_2to1_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 4;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic [IW-1:0] s0_ARID, s1_ARID, m_ARID, s0_RID, s1_RID, m_RID;
    logic [AW-1:0] s0_ARADDR, s1_ARADDR, m_ARADDR;
    logic [3:0]    s0_ARLEN, s1_ARLEN, m_ARLEN;
    logic [2:0]    s0_ARSIZE, s1_ARSIZE, m_ARSIZE;
    logic [1:0]    s0_ARBURST, s1_ARBURST, m_ARBURST;
    logic          s0_ARVALID, s1_ARVALID, m_ARVALID;
    logic          s0_ARREADY, s1_ARREADY, m_ARREADY;
    logic [DW-1:0] s0_RDATA, s1_RDATA, m_RDATA;
    logic [1:0]    s0_RRESP, s1_RRESP, m_RRESP;
    logic          s0_RLAST, s1_RLAST, m_RLAST;
    logic          s0_RVALID, s1_RVALID, m_RVALID;
    logic          s0_RREADY, s1_RREADY, m_RREADY;
    logic          len_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 ACLK = ~ACLK;

    axi_rd_arbiter_2to1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s0_ARID(s0_ARID), .s0_ARADDR(s0_ARADDR), .s0_ARLEN(s0_ARLEN), .s0_ARSIZE(s0_ARSIZE),
        .s0_ARBURST(s0_ARBURST), .s0_ARVALID(s0_ARVALID), .s0_ARREADY(s0_ARREADY),
        .s0_RID(s0_RID), .s0_RDATA(s0_RDATA), .s0_RRESP(s0_RRESP), .s0_RLAST(s0_RLAST),
        .s0_RVALID(s0_RVALID), .s0_RREADY(s0_RREADY),
        .s1_ARID(s1_ARID), .s1_ARADDR(s1_ARADDR), .s1_ARLEN(s1_ARLEN), .s1_ARSIZE(s1_ARSIZE),
        .s1_ARBURST(s1_ARBURST), .s1_ARVALID(s1_ARVALID), .s1_ARREADY(s1_ARREADY),
        .s1_RID(s1_RID), .s1_RDATA(s1_RDATA), .s1_RRESP(s1_RRESP), .s1_RLAST(s1_RLAST),
        .s1_RVALID(s1_RVALID), .s1_RREADY(s1_RREADY),
        .m_ARID(m_ARID), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE),
        .m_ARBURST(m_ARBURST), .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
        .m_RID(m_RID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RLAST(m_RLAST),
        .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .len_err(len_err)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Raise ARVALID on one port, wait (bounded) for its ARREADY, complete the handshake.
    task automatic send_ar(input bit p, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [3:0] len);
        if (p) begin
            s1_ARID = id; s1_ARADDR = addr; s1_ARLEN = len;
            s1_ARSIZE = SIZE_4B; s1_ARBURST = BURST_INCR; s1_ARVALID = 1'b1;
        end else begin
            s0_ARID = id; s0_ARADDR = addr; s0_ARLEN = len;
            s0_ARSIZE = SIZE_4B; s0_ARBURST = BURST_INCR; s0_ARVALID = 1'b1;
        end
        #1;
        for (int i = 0; i < 8 && !(p ? s1_ARREADY : s0_ARREADY); i++) tick();
        vectors++;
        if (!(p ? s1_ARREADY : s0_ARREADY)) begin
            miscompares++;
            $display("FAIL ar_wait port=%0d ARREADY got 0 want 1 within 8 cycles", p);
        end
        tick();
        s0_ARVALID = 1'b0;
        s1_ARVALID = 1'b0;
    endtask

    task automatic addr_phase();
        m_ARREADY = 1'b1;
        tick();
        m_ARREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        {s0_ARID, s0_ARADDR, s0_ARLEN, s0_ARSIZE, s0_ARBURST, s0_ARVALID, s0_RREADY} = '0;
        {s1_ARID, s1_ARADDR, s1_ARLEN, s1_ARSIZE, s1_ARBURST, s1_ARVALID, s1_RREADY} = '0;
        {m_ARREADY, m_RID, m_RDATA, m_RRESP, m_RLAST, m_RVALID} = '0;
        tick(); tick();
        vectors++; if (m_ARVALID !== 1'b0) begin miscompares++; $display("FAIL rst_arvalid got %b want 0", m_ARVALID); end
        vectors++; if (len_err !== 1'b0) begin miscompares++; $display("FAIL rst_len_err got %b want 0", len_err); end
        vectors++; if (m_ARADDR !== '0 || m_ARLEN !== 4'd0 || m_ARID !== '0) begin miscompares++; $display("FAIL rst_payload got addr=%h len=%h id=%h want 0", m_ARADDR, m_ARLEN, m_ARID); end
        vectors++; if ({s0_ARREADY, s1_ARREADY, m_RREADY, s0_RVALID, s1_RVALID} !== 5'b0) begin miscompares++; $display("FAIL rst_comb got %b want 00000", {s0_ARREADY, s1_ARREADY, m_RREADY, s0_RVALID, s1_RVALID}); end
        ARESETn = 1'b1;
        tick();
    endtask

    task automatic test_s0_single();
        send_ar(1'b0, 4'd5, 32'h100, 4'd3);
        vectors++; if (m_ARVALID !== 1'b1) begin miscompares++; $display("FAIL t1_arvalid_t1 got %b want 1", m_ARVALID); end
        vectors++; if (m_ARADDR !== 32'h100 || m_ARLEN !== 4'd3 || m_ARID !== 4'd5 || m_ARSIZE !== SIZE_4B) begin miscompares++; $display("FAIL t1_payload got addr=%h len=%h id=%h size=%h want 100/3/5/2", m_ARADDR, m_ARLEN, m_ARID, m_ARSIZE); end
        vectors++; if (s0_ARREADY !== 1'b0) begin miscompares++; $display("FAIL t1_addr_arready got %b want 0", s0_ARREADY); end
        tick();
        vectors++; if (m_ARVALID !== 1'b1) begin miscompares++; $display("FAIL t1_arvalid_hold got %b want 1", m_ARVALID); end
        addr_phase();
        vectors++; if (m_ARVALID !== 1'b0) begin miscompares++; $display("FAIL t1_arvalid_drop got %b want 0", m_ARVALID); end
        s0_RREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_RVALID = 1'b1; m_RDATA = 32'hA0 + i; m_RLAST = (i == 3);
            #1;
            vectors++; if (s0_RVALID !== 1'b1 || s1_RVALID !== 1'b0 || s0_RDATA !== 32'hA0 + i) begin miscompares++; $display("FAIL t1_beat%0d got v0=%b v1=%b data=%h want 1/0/%h", i, s0_RVALID, s1_RVALID, s0_RDATA, 32'hA0 + i); end
            tick();
            vectors++; if (len_err !== 1'b0) begin miscompares++; $display("FAIL t1_len_err%0d got %b want 0", i, len_err); end
        end
        m_RLAST = 1'b0;
        #1;
        vectors++; if (s0_RVALID !== 1'b0 || m_RREADY !== 1'b0) begin miscompares++; $display("FAIL t1_idle got v0=%b rready=%b want 0/0", s0_RVALID, m_RREADY); end
        m_RVALID = 1'b0; s0_RREADY = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        s0_ARID = 4'd1; s0_ARADDR = 32'h200; s0_ARLEN = 4'd1; s0_ARSIZE = SIZE_4B; s0_ARBURST = BURST_INCR;
        s1_ARID = 4'd2; s1_ARADDR = 32'h300; s1_ARLEN = 4'd0; s1_ARSIZE = SIZE_4B; s1_ARBURST = BURST_INCR;
        s0_ARVALID = 1'b1; s1_ARVALID = 1'b1;
        #1;
        vectors++; if (s1_ARREADY !== 1'b1 || s0_ARREADY !== 1'b0) begin miscompares++; $display("FAIL t2_prio got r1=%b r0=%b want 1/0", s1_ARREADY, s0_ARREADY); end
        tick();
        s1_ARVALID = 1'b0;
        #1;
        vectors++; if (m_ARADDR !== 32'h300 || s0_ARREADY !== 1'b0) begin miscompares++; $display("FAIL t2_first got addr=%h r0=%b want 300/0", m_ARADDR, s0_ARREADY); end
        addr_phase();
        m_RVALID = 1'b1; m_RLAST = 1'b1; m_RDATA = 32'hB0; s1_RREADY = 1'b1;
        #1;
        vectors++; if (s1_RVALID !== 1'b1 || s0_RVALID !== 1'b0) begin miscompares++; $display("FAIL t2_s1_beat got v1=%b v0=%b want 1/0", s1_RVALID, s0_RVALID); end
        tick();
        m_RVALID = 1'b0; m_RLAST = 1'b0; s1_RREADY = 1'b0;
        #1;
        vectors++; if (s0_ARREADY !== 1'b1) begin miscompares++; $display("FAIL t2_bubble got r0=%b want 1", s0_ARREADY); end
        tick();
        s0_ARVALID = 1'b0;
        vectors++; if (m_ARADDR !== 32'h200 || m_ARLEN !== 4'd1 || m_ARVALID !== 1'b1) begin miscompares++; $display("FAIL t2_second got addr=%h len=%h v=%b want 200/1/1", m_ARADDR, m_ARLEN, m_ARVALID); end
        addr_phase();
        s0_RREADY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_RVALID = 1'b1; m_RLAST = (i == 1);
            #1;
            vectors++; if (s0_RVALID !== 1'b1 || s1_RVALID !== 1'b0) begin miscompares++; $display("FAIL t2_s0_beat%0d got v0=%b v1=%b want 1/0", i, s0_RVALID, s1_RVALID); end
            tick();
            vectors++; if (len_err !== 1'b0) begin miscompares++; $display("FAIL t2_len_err%0d got %b want 0", i, len_err); end
        end
        m_RVALID = 1'b0; m_RLAST = 1'b0; s0_RREADY = 1'b0;
        tick();
    endtask

    task automatic test_rready_toggle();
        int  n;
        logic rdy;
        send_ar(1'b0, 4'd1, 32'h400, 4'd3);
        addr_phase();
        n = 0;
        for (int c = 0; c < 16 && n < 4; c++) begin
            rdy = (c % 2 == 0);
            s0_RREADY = rdy; m_RVALID = 1'b1; m_RDATA = 32'hC0 + n; m_RLAST = (n == 3);
            #1;
            vectors++; if (m_RREADY !== rdy || s1_RVALID !== 1'b0) begin miscompares++; $display("FAIL t3_mirror c=%0d got rready=%b v1=%b want %b/0", c, m_RREADY, s1_RVALID, rdy); end
            if (s0_RVALID && rdy) begin
                vectors++; if (s0_RDATA !== 32'hC0 + n) begin miscompares++; $display("FAIL t3_data%0d got %h want %h", n, s0_RDATA, 32'hC0 + n); end
                n++;
            end
            tick();
            vectors++; if (len_err !== 1'b0) begin miscompares++; $display("FAIL t3_len_err c=%0d got %b want 0", c, len_err); end
        end
        vectors++; if (n != 4) begin miscompares++; $display("FAIL t3_beats got %0d want 4", n); end
        m_RVALID = 1'b0; m_RLAST = 1'b0; s0_RREADY = 1'b0;
        tick();
    endtask

    task automatic test_len_err();
        send_ar(1'b0, 4'd2, 32'h500, 4'd3);
        addr_phase();
        s0_RREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_RVALID = 1'b1; m_RLAST = (i == 2);
            tick();
            vectors++; if (len_err !== (i == 2)) begin miscompares++; $display("FAIL t4a_beat%0d len_err got %b want %b", i, len_err, (i == 2)); end
        end
        m_RVALID = 1'b0; m_RLAST = 1'b0; s0_RREADY = 1'b0;
        tick();
        vectors++; if (len_err !== 1'b0) begin miscompares++; $display("FAIL t4a_pulse got %b want 0", len_err); end
        send_ar(1'b1, 4'd3, 32'h600, 4'd1);
        addr_phase();
        s1_RREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_RVALID = 1'b1; m_RLAST = (i == 2);
            #1;
            vectors++; if (s1_RVALID !== 1'b1) begin miscompares++; $display("FAIL t4b_in_data%0d got v1=%b want 1", i, s1_RVALID); end
            tick();
            vectors++; if (len_err !== (i != 0)) begin miscompares++; $display("FAIL t4b_beat%0d len_err got %b want %b", i, len_err, (i != 0)); end
        end
        m_RLAST = 1'b0;
        #1;
        vectors++; if (s1_RVALID !== 1'b0) begin miscompares++; $display("FAIL t4b_idle got v1=%b want 0", s1_RVALID); end
        m_RVALID = 1'b0; s1_RREADY = 1'b0;
        tick();
        vectors++; if (len_err !== 1'b0) begin miscompares++; $display("FAIL t4b_pulse got %b want 0", len_err); end
    endtask

    task automatic test_rvalid_idle();
        m_RVALID = 1'b1; s0_RREADY = 1'b1; s1_RREADY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if ({m_RREADY, s0_RVALID, s1_RVALID} !== 3'b000) begin miscompares++; $display("FAIL t5_idle%0d got %b want 000", i, {m_RREADY, s0_RVALID, s1_RVALID}); end
            tick();
        end
        m_RVALID = 1'b0; s0_RREADY = 1'b0; s1_RREADY = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        send_ar(1'b0, 4'd4, 32'h700, 4'd3);
        addr_phase();
        s0_RREADY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_RVALID = 1'b1;
            tick();
        end
        #1;
        vectors++; if (s0_RVALID !== 1'b1) begin miscompares++; $display("FAIL t6_pre got v0=%b want 1", s0_RVALID); end
        ARESETn = 1'b0;
        #1;
        vectors++; if ({m_RREADY, m_ARVALID, s0_RVALID} !== 3'b000 || m_ARADDR !== '0) begin miscompares++; $display("FAIL t6_async got rdy/arv/v0=%b addr=%h want 000/0", {m_RREADY, m_ARVALID, s0_RVALID}, m_ARADDR); end
        m_RVALID = 1'b0; s0_RREADY = 1'b0;
        tick();
        ARESETn = 1'b1;
        tick();
        send_ar(1'b1, 4'd5, 32'h800, 4'd0);
        vectors++; if (m_ARADDR !== 32'h800 || m_ARID !== 4'd5 || m_ARVALID !== 1'b1) begin miscompares++; $display("FAIL t6_fresh_ar got addr=%h id=%h v=%b want 800/5/1", m_ARADDR, m_ARID, m_ARVALID); end
        addr_phase();
        m_RVALID = 1'b1; m_RLAST = 1'b1; m_RID = 4'd5; m_RDATA = 32'hD0; s1_RREADY = 1'b1;
        #1;
        vectors++; if (s1_RVALID !== 1'b1 || s1_RID !== 4'd5 || s1_RDATA !== 32'hD0) begin miscompares++; $display("FAIL t6_beat got v1=%b id=%h data=%h want 1/5/d0", s1_RVALID, s1_RID, s1_RDATA); end
        tick();
        vectors++; if (len_err !== 1'b0) begin miscompares++; $display("FAIL t6_len_err got %b want 0", len_err); end
        m_RLAST = 1'b0;
        #1;
        vectors++; if (s1_RVALID !== 1'b0) begin miscompares++; $display("FAIL t6_idle got v1=%b want 0", s1_RVALID); end
        m_RVALID = 1'b0; s1_RREADY = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_s0_single();
        test_priority();
        test_rready_toggle();
        test_len_err();
        test_rvalid_idle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
